vga_screen_fader: RTL and testbench
===================================

# vga_screen_fader

Parametrised N-channel VGA stream selector that replaces hard state-to-screen muxing with frame-synchronous switching and a fade-to-black / fade-in transition. It sits between the per-screen draw modules and the downstream overlay/output stages. Channel switches happen only at frame boundaries, so the output never tears. RGB is brightness-scaled during transitions; all timing signals pass through with fixed latency.

## Interface
Parameters:
- N_CH, 4: number of input screen channels (2..16)
- SEL_W, $clog2(N_CH): width of channel select
- RGB_W, 12: pixel width; three equal components, RGB_W % 3 == 0
- FADE_LOG2, 2: fade length; level range 0..2^FADE_LOG2 (0..4)
- RESET_SEL, 0: channel active after reset

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- sel_req  in  SEL_W  requested channel (from game state decode)
- in_hcount / in_vcount  in  N_CH*11 each  per-channel counters, channel k at [k*11 +: 11]
- in_hsync, in_vsync, in_hblnk, in_vblnk  in  N_CH each  per-channel sync/blank
- in_rgb  in  N_CH*RGB_W  per-channel pixel
- out_hcount, out_vcount  out  11  selected counters
- out_hsync, out_vsync, out_hblnk, out_vblnk  out  1  selected sync/blank
- out_rgb  out  RGB_W  scaled pixel
- active_sel  out  SEL_W  channel currently driving the output
- busy  out  1  high whenever state != IDLE

## Operation
- Frame boundary (fb): rising edge of in_vblnk of the channel selected by active_sel, detected against a registered copy vblnk_q (reset 0).
- Internal: state, target (SEL_W), level (FADE_LOG2+1 bits).
- States: IDLE, FADE_OUT, FADE_IN.
- IDLE: level = 2^FADE_LOG2. If sel_req < N_CH and sel_req != active_sel: target <= sel_req, go FADE_OUT (not gated by fb).
- FADE_OUT: on each fb, target <= sel_req if sel_req < N_CH; if level > 0, level <= level-1; else active_sel <= target, go FADE_IN.
- FADE_IN: on each fb, level <= level+1; when incremented value equals 2^FADE_LOG2, go IDLE. sel_req ignored.
- target == active_sel at swap: swap is a no-op; the fade-in still completes.
- sel_req >= N_CH: ignored in every state.
- Scaling per component c (width RGB_W/3): out_c = (c * level) >> FADE_LOG2, computed at full product width (RGB_W/3 + FADE_LOG2 + 1), then truncated. level = max gives c exactly; level = 0 gives 0.
- Timing fields (counts, syncs, blanks) always come from active_sel, unscaled.

## Timing
- All outputs are registered: latency of exactly 1 clk from inputs, identical for rgb and timing, so pixel/timing alignment is preserved.
- Mux selection and scaling use the active_sel/level values of the same cycle; an update of active_sel/level at an fb affects output from the following cycle, which falls inside vblank.
- Reset values: all out_* = 0, active_sel = RESET_SEL, level = 2^FADE_LOG2, state IDLE, busy 0, target = RESET_SEL.
- Transition cost: fb count from FADE_OUT entry to IDLE = 2*2^FADE_LOG2 + 1 (FADE_LOG2=2: 4 fbs down to level 0, 1 fb swap, 4 fbs up); the level-0 frame is fully black.
- Reset mid-transition: returns to RESET_SEL at full brightness immediately, with no fade.
- If vblnk is high when reset is released, no fb occurs until it falls and rises again.

## Test plan
- Reset: assert rst 3 clk with random inputs -> all out_* 0, active_sel=0, busy=0; first clk after release: out equals channel 0 inputs from the prior cycle.
- Pass-through: IDLE, ch0 rgb=0xF84, hcount=123 -> out_rgb=0xF84, out_hcount=123 exactly 1 clk later; syncs aligned.
- Full transition, FADE_LOG2=2, ch0 rgb=0xFFF, ch2 rgb=0x840, sel_req 0->2 -> busy=1 next clk. Frame levels 3,2,1,0 (rgb 0xBBB,0x777,0x333,0x000); swap; then ch2 at levels 1..4 (0x210,0x420,0x630,0x840). busy=0 after the 9th fb.
- Retarget: during FADE_OUT, sel_req 2->3 before level 0 -> swap lands on 3. A sel_req change during FADE_IN is ignored, then starts a new transition once IDLE.
- Invalid select, N_CH=3: sel_req=3 -> no transition, busy stays 0, active_sel unchanged.
- Reset mid-fade: rst at level 1 of FADE_OUT -> next clk active_sel=RESET_SEL, level max, busy 0, no black frame.

Source files
------------

// File: rtl/vga_screen_fader_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_screen_fader_if
//  Purpose  : Bundle of the screen fader's per-channel VGA inputs, the
//             selected/scaled VGA output and the channel-select status.
//  Ports    : sel_req                      requested channel
//             in_hcount/in_vcount          per-channel counters (11 b each)
//             in_hsync/vsync/hblnk/vblnk   per-channel sync and blank
//             in_rgb                       per-channel pixel (RGB_W each)
//             out_*                        selected, registered VGA stream
//             active_sel, busy             fader status
//  Revision : 1.0  initial release
// ============================================================================
interface vga_screen_fader_if #(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH),
    parameter int RGB_W = 12
);
    logic [SEL_W-1:0]      sel_req;
    logic [N_CH*11-1:0]    in_hcount;
    logic [N_CH*11-1:0]    in_vcount;
    logic [N_CH-1:0]       in_hsync;
    logic [N_CH-1:0]       in_vsync;
    logic [N_CH-1:0]       in_hblnk;
    logic [N_CH-1:0]       in_vblnk;
    logic [N_CH*RGB_W-1:0] in_rgb;
    logic [10:0]           out_hcount;
    logic [10:0]           out_vcount;
    logic                  out_hsync;
    logic                  out_vsync;
    logic                  out_hblnk;
    logic                  out_vblnk;
    logic [RGB_W-1:0]      out_rgb;
    logic [SEL_W-1:0]      active_sel;
    logic                  busy;

    // Side that produces screen streams and consumes the faded output
    modport master (
        output sel_req, in_hcount, in_vcount, in_hsync, in_vsync,
               in_hblnk, in_vblnk, in_rgb,
        input  out_hcount, out_vcount, out_hsync, out_vsync,
               out_hblnk, out_vblnk, out_rgb, active_sel, busy
    );

    // The fader itself
    modport slave (
        input  sel_req, in_hcount, in_vcount, in_hsync, in_vsync,
               in_hblnk, in_vblnk, in_rgb,
        output out_hcount, out_vcount, out_hsync, out_vsync,
               out_hblnk, out_vblnk, out_rgb, active_sel, busy
    );
endinterface
`default_nettype wire

// File: rtl/vga_screen_fader.sv
`default_nettype none
// ============================================================================
//  Module   : vga_screen_fader
//  Purpose  : N-channel VGA stream selector. Channel changes are made only
//             at frame boundaries (rising vblank of the active channel) and
//             are wrapped in a fade-to-black / fade-in of the RGB data.
//             All outputs are registered with one clock of latency.
//  Ports    : clk, rst    clock, synchronous active-high reset
//             bus (slave) sel_req and per-channel VGA inputs in,
//                         selected VGA stream, active_sel and busy out
//  Revision : 1.0  initial release
// ============================================================================
module vga_screen_fader #(
    parameter int N_CH      = 4,
    parameter int SEL_W     = $clog2(N_CH),
    parameter int RGB_W     = 12,
    parameter int FADE_LOG2 = 2,
    parameter int RESET_SEL = 0
) (
    input  logic               clk,
    input  logic               rst,
    vga_screen_fader_if.slave  bus
);

    localparam int c_cw = RGB_W / 3;          // colour component width
    localparam int c_lw = FADE_LOG2 + 1;      // level width (0..2^FADE_LOG2)
    localparam int c_pw = c_cw + c_lw;        // full product width

    localparam logic [c_lw-1:0]  c_level_max = c_lw'(2 ** FADE_LOG2);
    localparam logic [SEL_W-1:0] c_reset_sel = SEL_W'(RESET_SEL);

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_fade_out = 2'd1;
    localparam logic [1:0] c_st_fade_in  = 2'd2;

    logic [1:0]       r_state;
    logic [SEL_W-1:0] r_target;
    logic [c_lw-1:0]  r_level;
    logic [SEL_W-1:0] r_active_sel;
    logic             r_vblnk_q;

    logic [10:0]      r_out_hcount;
    logic [10:0]      r_out_vcount;
    logic             r_out_hsync;
    logic             r_out_vsync;
    logic             r_out_hblnk;
    logic             r_out_vblnk;
    logic [RGB_W-1:0] r_out_rgb;

    logic [10:0]      w_hcount;
    logic [10:0]      w_vcount;
    logic             w_hsync;
    logic             w_vsync;
    logic             w_hblnk;
    logic             w_vblnk;
    logic [RGB_W-1:0] w_rgb;
    logic [RGB_W-1:0] w_rgb_scaled;
    logic             w_fb;
    logic             w_sel_valid;

    // Channel mux driven by the currently active channel
    always_comb begin
        w_hcount = '0;
        w_vcount = '0;
        w_hsync  = 1'b0;
        w_vsync  = 1'b0;
        w_hblnk  = 1'b0;
        w_vblnk  = 1'b0;
        w_rgb    = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (r_active_sel == SEL_W'(k)) begin
                w_hcount = bus.in_hcount[k*11 +: 11];
                w_vcount = bus.in_vcount[k*11 +: 11];
                w_hsync  = bus.in_hsync[k];
                w_vsync  = bus.in_vsync[k];
                w_hblnk  = bus.in_hblnk[k];
                w_vblnk  = bus.in_vblnk[k];
                w_rgb    = bus.in_rgb[k*RGB_W +: RGB_W];
            end
        end
    end

    // Extra MSB lets N_CH == 2^SEL_W compare correctly
    assign w_sel_valid = ({1'b0, bus.sel_req} < (SEL_W+1)'(N_CH));
    assign w_fb        = w_vblnk & ~r_vblnk_q;

    // Per-component brightness scaling: (c * level) >> FADE_LOG2
    for (genvar i = 0; i < 3; i++) begin : g_comp
        logic [c_pw-1:0] w_prod;
        assign w_prod = c_pw'(w_rgb[i*c_cw +: c_cw]) * c_pw'(r_level);
        assign w_rgb_scaled[i*c_cw +: c_cw] = w_prod[FADE_LOG2 +: c_cw];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_target     <= c_reset_sel;
            r_level      <= c_level_max;
            r_active_sel <= c_reset_sel;
            r_vblnk_q    <= 1'b0;
            r_out_hcount <= '0;
            r_out_vcount <= '0;
            r_out_hsync  <= 1'b0;
            r_out_vsync  <= 1'b0;
            r_out_hblnk  <= 1'b0;
            r_out_vblnk  <= 1'b0;
            r_out_rgb    <= '0;
        end else begin
            r_vblnk_q    <= w_vblnk;
            r_out_hcount <= w_hcount;
            r_out_vcount <= w_vcount;
            r_out_hsync  <= w_hsync;
            r_out_vsync  <= w_vsync;
            r_out_hblnk  <= w_hblnk;
            r_out_vblnk  <= w_vblnk;
            r_out_rgb    <= w_rgb_scaled;

            case (r_state)
                c_st_idle: begin
                    r_level <= c_level_max;
                    // Fade-out starts at once; only the steps are frame-gated
                    if (w_sel_valid && (bus.sel_req != r_active_sel)) begin
                        r_target <= bus.sel_req;
                        r_state  <= c_st_fade_out;
                    end
                end
                c_st_fade_out: begin
                    if (w_fb) begin
                        if (w_sel_valid) begin
                            r_target <= bus.sel_req;
                        end
                        if (r_level != '0) begin
                            r_level <= r_level - c_lw'(1);
                        end else begin
                            // Swap uses the target held through the black frame
                            r_active_sel <= r_target;
                            r_state      <= c_st_fade_in;
                        end
                    end
                end
                c_st_fade_in: begin
                    if (w_fb) begin
                        r_level <= r_level + c_lw'(1);
                        if ((r_level + c_lw'(1)) == c_level_max) begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.out_hcount = r_out_hcount;
    assign bus.out_vcount = r_out_vcount;
    assign bus.out_hsync  = r_out_hsync;
    assign bus.out_vsync  = r_out_vsync;
    assign bus.out_hblnk  = r_out_hblnk;
    assign bus.out_vblnk  = r_out_vblnk;
    assign bus.out_rgb    = r_out_rgb;
    assign bus.active_sel = r_active_sel;
    assign bus.busy       = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_vga_screen_fader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_screen_fader
//  Purpose  : Randomised bench for vga_screen_fader with a frame-level
//             reference model and a scoreboard checked by a monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_screen_fader;

    localparam int N_CH      = 5;
    localparam int SEL_W     = 3;
    localparam int RGB_W     = 12;
    localparam int FADE_LOG2 = 2;
    localparam int RESET_SEL = 0;
    localparam int CW        = RGB_W / 3;
    localparam int LMAX      = 2 ** FADE_LOG2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_screen_fader_if #(.N_CH(N_CH), .SEL_W(SEL_W), .RGB_W(RGB_W)) bus ();

    vga_screen_fader #(
        .N_CH(N_CH), .SEL_W(SEL_W), .RGB_W(RGB_W),
        .FADE_LOG2(FADE_LOG2), .RESET_SEL(RESET_SEL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [10:0]      hc;
        logic [10:0]      vc;
        logic [3:0]       sync;   // {hsync, vsync, hblnk, vblnk}
        logic [RGB_W-1:0] rgb;
        logic [SEL_W-1:0] act;
        logic             busy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a transition is a count of frame boundaries seen
    // since it began (-1 = idle). Brightness and swap follow from the count.
    int m_active;
    int m_target;
    int m_steps;
    logic m_prev_vb;

    int cnt [N_CH];
    int rgb_mode;
    int hc0_fix;
    logic [RGB_W-1:0] fix_rgb [N_CH];

    function automatic int level_of(input int s);
        if (s < 0)     return LMAX;
        if (s <= LMAX) return LMAX - s;
        return s - LMAX - 1;
    endfunction

    task automatic model_step(input logic r, input logic [SEL_W-1:0] sel);
        exp_t e;
        int   a;
        int   lvl;
        int   old_t;
        logic fb;
        logic valid;
        a = m_active;
        if (r) begin
            e.hc = '0; e.vc = '0; e.sync = '0; e.rgb = '0;
            m_active  = RESET_SEL;
            m_target  = RESET_SEL;
            m_steps   = -1;
            m_prev_vb = 1'b0;
        end else begin
            lvl    = level_of(m_steps);
            e.hc   = bus.in_hcount[a*11 +: 11];
            e.vc   = bus.in_vcount[a*11 +: 11];
            e.sync = {bus.in_hsync[a], bus.in_vsync[a], bus.in_hblnk[a], bus.in_vblnk[a]};
            for (int i = 0; i < 3; i++) begin
                logic [CW-1:0] c;
                c = bus.in_rgb[a*RGB_W + i*CW +: CW];
                e.rgb[i*CW +: CW] = CW'((int'(c) * lvl) >> FADE_LOG2);
            end
            fb        = bus.in_vblnk[a] && !m_prev_vb;
            m_prev_vb = bus.in_vblnk[a];
            valid     = (int'(sel) < N_CH);
            if (m_steps < 0) begin
                if (valid && int'(sel) != m_active) begin
                    m_target = int'(sel);
                    m_steps  = 0;
                end
            end else if (fb) begin
                if (m_steps <= LMAX) begin
                    old_t = m_target;
                    if (valid) m_target = int'(sel);
                    if (m_steps == LMAX) m_active = old_t;
                end
                m_steps++;
                if (m_steps == 2*LMAX + 1) m_steps = -1;
            end
        end
        e.act  = SEL_W'(m_active);
        e.busy = (m_steps >= 0);
        sb.push_back(e);
    endtask

    // Inputs change on the falling edge; each channel runs its own frame.
    task automatic drive_cycle(input logic r, input logic [SEL_W-1:0] sel);
        @(negedge clk);
        rst         = r;
        bus.sel_req = sel;
        for (int k = 0; k < N_CH; k++) begin
            cnt[k] = (cnt[k] + 1) % (24 + 2*k);
            bus.in_vblnk[k]            = (cnt[k] >= 18 + 2*k);
            bus.in_hsync[k]            = 1'($urandom);
            bus.in_vsync[k]            = 1'($urandom);
            bus.in_hblnk[k]            = 1'($urandom);
            bus.in_hcount[k*11 +: 11]  = 11'($urandom);
            bus.in_vcount[k*11 +: 11]  = 11'(cnt[k]);
            bus.in_rgb[k*RGB_W +: RGB_W] = (rgb_mode != 0) ? fix_rgb[k] : RGB_W'($urandom);
        end
        if (hc0_fix >= 0) bus.in_hcount[10:0] = 11'(hc0_fix);
        model_step(r, sel);
    endtask

    task automatic wait_idle(input logic [SEL_W-1:0] sel);
        int n;
        n = 0;
        while (m_steps >= 0 && n < 2000) begin
            drive_cycle(1'b0, sel);
            n++;
        end
        if (m_steps >= 0) begin
            checks++; errors++;
            $display("FAIL wait_idle: transition still running after %0d cycles, required idle", n);
        end
    endtask

    task automatic wait_steps(input int s, input logic [SEL_W-1:0] sel);
        int n;
        n = 0;
        while (m_steps != s && n < 2000) begin
            drive_cycle(1'b0, sel);
            n++;
        end
        if (m_steps != s) begin
            checks++; errors++;
            $display("FAIL wait_steps: step %0d, required %0d", m_steps, s);
        end
    endtask

    // Monitor: every clock the DUT presents one registered output word.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks += 4;
            if (bus.out_rgb !== e.rgb) begin
                errors++;
                $display("FAIL rgb: got %h, required %h at %0t", bus.out_rgb, e.rgb, $time);
            end
            if ({bus.out_hcount, bus.out_vcount,
                 bus.out_hsync, bus.out_vsync, bus.out_hblnk, bus.out_vblnk} !==
                {e.hc, e.vc, e.sync}) begin
                errors++;
                $display("FAIL timing: got hc=%0d vc=%0d sync=%b, required hc=%0d vc=%0d sync=%b at %0t",
                         bus.out_hcount, bus.out_vcount,
                         {bus.out_hsync, bus.out_vsync, bus.out_hblnk, bus.out_vblnk},
                         e.hc, e.vc, e.sync, $time);
            end
            if (bus.active_sel !== e.act) begin
                errors++;
                $display("FAIL active_sel: got %0d, required %0d at %0t", bus.active_sel, e.act, $time);
            end
            if (bus.busy !== e.busy) begin
                errors++;
                $display("FAIL busy: got %b, required %b at %0t", bus.busy, e.busy, $time);
            end
        end
    end

    initial begin
        logic [SEL_W-1:0] sel;
        rst           = 1'b1;
        bus.sel_req   = '0;
        bus.in_hcount = '0;
        bus.in_vcount = '0;
        bus.in_hsync  = '0;
        bus.in_vsync  = '0;
        bus.in_hblnk  = '0;
        bus.in_vblnk  = '0;
        bus.in_rgb    = '0;
        rgb_mode      = 0;
        hc0_fix       = -1;
        m_active      = RESET_SEL;
        m_target      = RESET_SEL;
        m_steps       = -1;
        m_prev_vb     = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            cnt[k]     = int'($urandom_range(0, 20));
            fix_rgb[k] = RGB_W'($urandom);
        end

        // Reset with random inputs, then plain pass-through
        repeat (3) drive_cycle(1'b1, SEL_W'($urandom));
        repeat (4) drive_cycle(1'b0, 3'd0);
        rgb_mode   = 1;
        hc0_fix    = 123;
        fix_rgb[0] = 12'hF84;
        repeat (4) drive_cycle(1'b0, 3'd0);
        hc0_fix    = -1;

        // Full transition 0 -> 2 with fixed colours
        fix_rgb[0] = 12'hFFF;
        fix_rgb[2] = 12'h840;
        drive_cycle(1'b0, 3'd2);
        wait_idle(3'd2);
        repeat (5) drive_cycle(1'b0, 3'd2);

        // Retarget during fade-out, then a request ignored during fade-in
        fix_rgb[1] = 12'h5A3;
        fix_rgb[3] = 12'hC6F;
        drive_cycle(1'b0, 3'd1);
        wait_steps(2, 3'd1);
        wait_steps(LMAX + 1, 3'd3);
        @(posedge clk); #2;
        checks++;
        if (bus.active_sel !== 3'd3) begin
            errors++;
            $display("FAIL retarget_swap: got %0d, required 3", bus.active_sel);
        end
        wait_idle(3'd0);
        drive_cycle(1'b0, 3'd0);
        wait_idle(3'd0);

        // Out-of-range selects are ignored
        rgb_mode = 0;
        repeat (60) drive_cycle(1'b0, SEL_W'($urandom_range(N_CH, 7)));

        // Reset during fade-out at level 1
        drive_cycle(1'b0, 3'd4);
        wait_steps(LMAX - 1, 3'd4);
        drive_cycle(1'b1, 3'd4);
        repeat (40) drive_cycle(1'b0, 3'd0);

        // Random select traffic with occasional resets
        sel = 3'd0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 40) == 0) sel = SEL_W'($urandom);
            if ($urandom_range(0, 3) == 0) rgb_mode = 1 - rgb_mode;
            drive_cycle(($urandom_range(0, 700) == 0), sel);
        end

        @(posedge clk); #3;
        @(posedge clk); #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
